// File: rtl/ir_pkg.sv
// Shared types, timing windows and command codes for the NEC IR decoder.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        REP_MARK
    } ir_state_e;

    localparam int DUR_W = 11;
    typedef logic [DUR_W-1:0] dur_t;

    // Phase windows in ticks, both ends inclusive.
    localparam int LEAD_MARK_MIN  = 800;
    localparam int LEAD_MARK_MAX  = 1000;
    localparam int LEAD_SPACE_MIN = 400;
    localparam int LEAD_SPACE_MAX = 500;
    localparam int REP_SPACE_MIN  = 200;
    localparam int REP_SPACE_MAX  = 250;
    localparam int MARK_MIN       = 40;
    localparam int MARK_MAX       = 70;
    localparam int ZERO_MIN       = 40;
    localparam int ZERO_MAX       = 70;
    localparam int ONE_MIN        = 140;
    localparam int ONE_MAX        = 200;

    localparam logic [7:0] CMD_FWD   = 8'h02;
    localparam logic [7:0] CMD_LEFT  = 8'h08;
    localparam logic [7:0] CMD_BRAKE = 8'h10;
    localparam logic [7:0] CMD_RIGHT = 8'h20;
    localparam logic [7:0] CMD_BACK  = 8'h80;

    // Received word as shifted in LSB first: addr lands in the low byte.
    typedef struct packed {
        logic [7:0] cmd_n;
        logic [7:0] cmd;
        logic [7:0] addr_n;
        logic [7:0] addr;
    } nec_frame_t;

    function automatic logic in_win(input dur_t d, input int lo, input int hi);
        return (d >= dur_t'(lo)) && (d <= dur_t'(hi));
    endfunction

endpackage

// File: rtl/ir_nec_decoder_if.sv
// IR line in, decoded command bus and event pulses out.
interface ir_nec_decoder_if;
    logic       ir_rx_n;
    logic [7:0] ir_cmd;
    logic [7:0] ir_addr;
    logic       cmd_valid;
    logic       repeat_pulse;
    logic       frame_err;

    modport master (
        input  ir_rx_n,
        output ir_cmd, ir_addr, cmd_valid, repeat_pulse, frame_err
    );

    modport slave (
        output ir_rx_n,
        input  ir_cmd, ir_addr, cmd_valid, repeat_pulse, frame_err
    );
endinterface

// File: rtl/ir_edge_timer.sv
// Synchronises the IR line, flags mark/space edges and times each phase in ticks.
module ir_edge_timer
    import ir_pkg::*;
#(
    parameter int TICK_DIV = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_n,
    output logic mark_start,
    output logic mark_end,
    output logic space_end,
    output logic tick,
    output dur_t dur
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_cnt;
    logic          sync1, sync2, edge_q, edge_det;

    // Idle line is space (1), so the chain resets high to avoid a fake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            edge_q <= 1'b1;
        end else begin
            sync1  <= rx_n;
            sync2  <= sync1;
            edge_q <= sync2;
        end
    end

    assign edge_det   = sync2 ^ edge_q;
    assign mark_start = edge_det & ~sync2;
    assign mark_end   = edge_det & sync2;
    assign space_end  = mark_start;
    assign tick       = (pre_cnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            dur     <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (edge_det)
                dur <= '0;
            else if (tick && dur != '1)
                dur <= dur + dur_t'(1);
        end
    end

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC frame/repeat decoder with a held command output that clears after a hold timeout.
module ir_nec_decoder
    import ir_pkg::*;
#(
    parameter int TICK_DIV      = 500,
    parameter int HOLD_TICKS    = 12000,
    parameter int TIMEOUT_TICKS = 1100
) (
    input  logic             clk,
    input  logic             rst,
    ir_nec_decoder_if.master bus
);
    logic       mark_start, mark_end, space_end, tick;
    dur_t       dur;
    ir_state_e  state;
    logic [4:0] bit_cnt;
    logic [31:0] shreg;
    logic [13:0] hold_cnt;
    logic [7:0] cmd_q, addr_q;
    logic       valid_q, rep_q, err_q;
    nec_frame_t frm;

    ir_edge_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .rx_n       (bus.ir_rx_n),
        .mark_start (mark_start),
        .mark_end   (mark_end),
        .space_end  (space_end),
        .tick       (tick),
        .dur        (dur)
    );

    assign frm = nec_frame_t'(shreg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            hold_cnt <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            rep_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            rep_q   <= 1'b0;
            err_q   <= 1'b0;

            // Hold expiry sits ahead of the FSM so a same-cycle accept overrides it.
            if (cmd_q != 8'h00 && tick) begin
                if (hold_cnt == 14'(HOLD_TICKS - 1)) begin
                    cmd_q    <= 8'h00;
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt + 14'(1);
                end
            end

            case (state)
                IDLE:
                    if (mark_start) state <= LEAD_MARK;
                LEAD_MARK:
                    if (mark_end) begin
                        if (in_win(dur, LEAD_MARK_MIN, LEAD_MARK_MAX)) state <= LEAD_SPACE;
                        else begin err_q <= 1'b1; state <= IDLE; end
                    end
                LEAD_SPACE:
                    if (space_end) begin
                        if (in_win(dur, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                            bit_cnt <= '0;
                            state   <= BIT_MARK;
                        end else if (in_win(dur, REP_SPACE_MIN, REP_SPACE_MAX)) begin
                            state <= REP_MARK;
                        end else begin
                            err_q <= 1'b1;
                            state <= IDLE;
                        end
                    end
                BIT_MARK:
                    if (mark_end) begin
                        if (in_win(dur, MARK_MIN, MARK_MAX)) state <= BIT_SPACE;
                        else begin err_q <= 1'b1; state <= IDLE; end
                    end
                BIT_SPACE:
                    if (space_end) begin
                        if (in_win(dur, ZERO_MIN, ZERO_MAX) || in_win(dur, ONE_MIN, ONE_MAX)) begin
                            shreg <= {in_win(dur, ONE_MIN, ONE_MAX), shreg[31:1]};
                            if (bit_cnt == 5'd31) begin
                                state <= STOP_MARK;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                state   <= BIT_MARK;
                            end
                        end else begin
                            err_q <= 1'b1;
                            state <= IDLE;
                        end
                    end
                STOP_MARK:
                    if (mark_end) begin
                        if (in_win(dur, MARK_MIN, MARK_MAX) &&
                            (frm.addr ^ frm.addr_n) == 8'hFF &&
                            (frm.cmd ^ frm.cmd_n) == 8'hFF) begin
                            cmd_q    <= frm.cmd;
                            addr_q   <= frm.addr;
                            valid_q  <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state <= IDLE;
                    end
                REP_MARK:
                    if (mark_end) begin
                        if (in_win(dur, MARK_MIN, MARK_MAX)) begin
                            // A repeat with nothing held has nothing to extend.
                            if (cmd_q != 8'h00) begin
                                rep_q    <= 1'b1;
                                hold_cnt <= '0;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                        state <= IDLE;
                    end
                default:
                    state <= IDLE;
            endcase

            if (state != IDLE && !mark_start && !mark_end && dur >= dur_t'(TIMEOUT_TICKS)) begin
                err_q <= 1'b1;
                state <= IDLE;
            end
        end
    end

    assign bus.ir_cmd       = cmd_q;
    assign bus.ir_addr      = addr_q;
    assign bus.cmd_valid    = valid_q;
    assign bus.repeat_pulse = rep_q;
    assign bus.frame_err    = err_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed NEC stimulus; expected events go to a queue checked by a separate monitor.
module tb_ir_nec_decoder;
    import ir_pkg::*;

    localparam int HOLD   = 8000;
    localparam int K_VALID = 0;
    localparam int K_REP   = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        string      tag;
        int         kind;
        logic [7:0] cmd;
        logic [7:0] addr;
        longint     at;
    } ev_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    longint cyc = 0;
    int     n_run = 0;
    int     n_fail = 0;
    ev_t    exp_q[$];
    longint last_rep;

    ir_nec_decoder_if bus();

    ir_nec_decoder #(.TICK_DIV(1), .HOLD_TICKS(HOLD), .TIMEOUT_TICKS(1100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push(input string tag, input int kind, input logic [7:0] c,
                        input logic [7:0] a, input longint at);
        ev_t e;
        e.tag = tag; e.kind = kind; e.cmd = c; e.addr = a; e.at = at;
        exp_q.push_back(e);
    endtask

    // Hold the line at lvl for n clocks; always entered and left at posedge+1.
    task automatic line(input logic lvl, input int n);
        bus.ir_rx_n = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_leader();
        line(1'b0, 900);
        line(1'b1, 450);
    endtask

    task automatic send_bit(input logic b);
        line(1'b0, 56);
        line(1'b1, b ? 169 : 56);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] an, input logic [7:0] c,
                              input logic [7:0] cn, input string tag, input int kind,
                              input logic [7:0] ecmd, input logic [7:0] eaddr);
        logic [31:0] w;
        w = {cn, c, an, a};
        send_leader();
        for (int i = 0; i < 32; i++) send_bit(w[i]);
        line(1'b0, 56);
        push(tag, kind, ecmd, eaddr, cyc + 3);
        line(1'b1, 200);
    endtask

    task automatic send_repeat(input bit want_pulse, input string tag,
                               input logic [7:0] ecmd, input logic [7:0] eaddr);
        line(1'b0, 900);
        line(1'b1, 225);
        line(1'b0, 56);
        last_rep = cyc + 3;
        if (want_pulse) push(tag, K_REP, ecmd, eaddr, last_rep);
        line(1'b1, 1000);
    endtask

    task automatic wait_until(input longint target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] outs();
        return {45'd0, bus.ir_cmd, bus.ir_addr, bus.cmd_valid, bus.repeat_pulse, bus.frame_err};
    endfunction

    always @(negedge clk) begin
        if (!rst && (bus.cmd_valid || bus.repeat_pulse || bus.frame_err)) begin
            int  kind;
            ev_t e;
            case ({bus.cmd_valid, bus.repeat_pulse, bus.frame_err})
                3'b100:  kind = K_VALID;
                3'b010:  kind = K_REP;
                3'b001:  kind = K_ERR;
                default: kind = 9;
            endcase
            if (exp_q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, want no pulse", kind, cyc);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_kind"}, 64'(kind), 64'(e.kind));
                check({e.tag, "_cmd"}, 64'(bus.ir_cmd), 64'(e.cmd));
                check({e.tag, "_addr"}, 64'(bus.ir_addr), 64'(e.addr));
                if (e.at >= 0) check({e.tag, "_latency"}, 64'(cyc), 64'(e.at));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with the line toggling
        bus.ir_rx_n = 1'b1;
        #2 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #3 bus.ir_rx_n = ~bus.ir_rx_n;
            #1 check("rst_outputs", outs(), 64'd0);
        end
        bus.ir_rx_n = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        line(1'b1, 100);
        check("post_rst_idle", outs(), 64'd0);

        // 2: valid frame addr 0x00 cmd FWD
        send_frame(8'h00, 8'hFF, CMD_FWD, ~CMD_FWD, "t2_fwd", K_VALID, CMD_FWD, 8'h00);
        check("t2_cmd_held", 64'(bus.ir_cmd), 64'(CMD_FWD));

        // 4: corrupt cmd_n while FWD is held
        send_frame(8'h00, 8'hFF, CMD_RIGHT, 8'hD0, "t4_bad_cmdn", K_ERR, CMD_FWD, 8'h00);
        check("t4_cmd_kept", 64'(bus.ir_cmd), 64'(CMD_FWD));

        // 3: LEFT, two repeats, then silence until the hold expires
        send_frame(8'h04, 8'hFB, CMD_LEFT, 8'hF7, "t3_left", K_VALID, CMD_LEFT, 8'h04);
        send_repeat(1'b1, "t3_rep1", CMD_LEFT, 8'h04);
        send_repeat(1'b1, "t3_rep2", CMD_LEFT, 8'h04);
        wait_until(last_rep + HOLD - 5);
        check("t3_hold_kept", 64'(bus.ir_cmd), 64'(CMD_LEFT));
        wait_until(last_rep + HOLD + 5);
        check("t3_hold_clear", 64'(bus.ir_cmd), 64'h00);
        check("t3_addr_kept", 64'(bus.ir_addr), 64'h04);

        // 5a: 5 ms leader mark
        line(1'b0, 500);
        push("t5_short_leader", K_ERR, 8'h00, 8'h04, cyc + 3);
        line(1'b1, 300);
        // 5b: 300-tick bit space
        send_leader();
        send_bit(1'b0);
        line(1'b0, 56);
        line(1'b1, 300);
        push("t5_long_space", K_ERR, 8'h00, 8'h04, cyc + 3);
        line(1'b0, 56);
        line(1'b1, 300);
        // 5c: line stuck at mark after the leader
        send_leader();
        push("t5_stuck_mark", K_ERR, 8'h00, 8'h04, -1);
        line(1'b0, 1300);
        line(1'b1, 300);
        // 5d: repeat with nothing held
        send_repeat(1'b0, "t5_rep_nocmd", 8'h00, 8'h00);
        check("t5_rep_nocmd_cmd", 64'(bus.ir_cmd), 64'h00);

        // 6: reset after 16 bits, then a clean BACK frame
        send_leader();
        for (int i = 0; i < 16; i++) send_bit(i[0] ^ i[2]);
        line(1'b0, 56);
        line(1'b1, 10);
        rst = 1'b1;
        #1 check("t6_rst_outputs", outs(), 64'd0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        line(1'b1, 200);
        send_frame(8'h5A, 8'hA5, CMD_BACK, 8'h7F, "t6_back", K_VALID, CMD_BACK, 8'h5A);
        check("t6_cmd_held", 64'(bus.ir_cmd), 64'(CMD_BACK));

        line(1'b1, 50);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_nec_decoder.md
Name: ir_nec_decoder

Overview:
Receives the raw demodulated IR line and decodes NEC-format remote frames. It drives the 8-bit command bus consumed by the motor direction logic, with one-hot codes 0x02/0x08/0x10/0x20/0x80 and 0x00 when nothing is held. The command is held while the key repeats and is cleared to 0x00 after a hold timeout. The block sits between the IR receiver pin and the motor controller.

Parameters:
TICK_DIV, 500, clk cycles per timing tick (10 us at 50 MHz); the bench may override this (e.g. 5) for speed. Tick thresholds are unchanged by the override.
HOLD_TICKS, 12000, ticks without a valid frame or repeat before ir_cmd clears (120 ms).
TIMEOUT_TICKS, 1100, ticks without an edge in any non-IDLE state before the frame is aborted.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
ir_rx_n  in  1  raw IR receiver output, asynchronous; 0 = mark (carrier), 1 = space
ir_cmd  out  8  decoded command, held; drives the motor controller command input
ir_addr  out  8  address of the last accepted frame
cmd_valid  out  1  1-clk pulse when a new frame is accepted
repeat_pulse  out  1  1-clk pulse when a valid repeat code is accepted
frame_err  out  1  1-clk pulse when a frame is rejected

Behaviour:
- Reset (async, active-high):
  - all outputs are 0.
  - sync registers = space; FSM = IDLE; counters = 0.
- Input synchronisation:
  - 2-FF synchroniser, then an edge register.
  - An edge is detected when sync stage 2 differs from the edge register.
  - FSM outputs update on the clk after edge detection, giving 3 clk latency from an ir_rx_n transition.
- Tick prescaler:
  - free-running counter 0..TICK_DIV-1; tick = 1 clk pulse at wrap.
- Duration counter:
  - 11 bits, incremented per tick, saturates at 2047.
  - On every edge, the duration of the phase just ended is classified, then the counter clears to 0.
- Acceptance windows, in ticks (inclusive):
  - leader mark 800..1000
  - leader space 400..500
  - repeat space 200..250
  - bit/stop mark 40..70
  - bit space 0 is 40..70; bit space 1 is 140..200.
- FSM states and transitions:
  - IDLE: mark start -> LEAD_MARK.
  - LEAD_MARK: mark end in window -> LEAD_SPACE; otherwise frame_err -> IDLE.
  - LEAD_SPACE: space end in leader window -> BIT_MARK with bit_cnt=0; in repeat window -> REP_MARK; otherwise frame_err -> IDLE.
  - BIT_MARK: mark end in window -> BIT_SPACE; otherwise error.
  - BIT_SPACE: space end classified as 0 or 1 and shifted into a 32-bit register, LSB first; any other duration is an error. bit_cnt==31 -> STOP_MARK, else bit_cnt+1 -> BIT_MARK.
  - STOP_MARK: mark end in window -> validate. If addr^addr_n==0xFF and cmd^cmd_n==0xFF: ir_cmd<=cmd, ir_addr<=addr, cmd_valid pulse. Otherwise frame_err. Either way -> IDLE.
  - REP_MARK: mark end in window -> repeat_pulse if ir_cmd!=0 (silently ignored if ir_cmd==0) -> IDLE; otherwise frame_err.
- Frame byte order: byte0=addr, byte1=addr_n, byte2=cmd, byte3=cmd_n.
- Timeout: in any state except IDLE, duration reaching TIMEOUT_TICKS -> frame_err pulse, IDLE.
- Errors never change ir_cmd or ir_addr.
- Hold timer:
  - 14 bits; clears on cmd_valid or repeat_pulse; counts ticks while ir_cmd!=0.
  - On reaching HOLD_TICKS: ir_cmd<=0x00, timer stops. ir_addr is kept.
- Simultaneous events: a hold expiry and a frame accept in the same clk -> the accept wins.
- Reset mid-frame: shift register and bit_cnt are discarded; no pulse is emitted.

Decomposition:
- Package ir_pkg holds:
  - state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_MARK);
  - window min/max localparams;
  - the command code constants CMD_FWD=0x02, CMD_LEFT=0x08, CMD_BRAKE=0x10, CMD_RIGHT=0x20, CMD_BACK=0x80.
- One sub-module, ir_edge_timer: synchroniser, edge detect, tick prescaler, saturating duration counter. It outputs mark_start, mark_end, space_end, dur, tick.

Test Plan:
1. Reset asserted at arbitrary time with ir_rx_n toggling -> all outputs 0 immediately, held 0 until first valid frame.
2. Full frame addr 0x00, cmd 0x02 (9 ms / 4.5 ms leader, 32 bits, stop mark) -> ir_cmd=0x02, ir_addr=0x00, cmd_valid high exactly 1 clk, 3 clk after the stop-mark end.
3. Frame cmd 0x08, then repeat code (9 ms / 2.25 ms / 0.56 ms) every 108 ms twice -> two repeat_pulse, ir_cmd stays 0x08. Then silence -> ir_cmd=0x00 HOLD_TICKS ticks after the last repeat.
4. Frame with cmd 0x20 and cmd_n 0xD0 while ir_cmd=0x02 held -> frame_err 1 clk, ir_cmd stays 0x02, no cmd_valid.
5. Leader mark 5 ms -> frame_err. Bit space 3 ms (300 ticks) -> frame_err. Line stuck at mark after the leader -> frame_err after 1100 ticks. Repeat code with ir_cmd=0 -> no pulse at all.
6. rst pulsed after 16 bits of a frame, then a clean frame cmd 0x80 -> no spurious pulses, ir_cmd=0x80, single cmd_valid.
